// File: rtl/fir_mac_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_mac_if                                                               |
// | Sample stream, sample RAM, coefficient ROM, ALU and result port bundle.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fir_mac_if #(
   parameter int NTAPS = 64,
   parameter int DW    = 16,
   parameter int ACCW  = 32
);
   localparam int AW = $clog2(NTAPS);

   logic                   in_valid;
   logic                   in_ready;
   logic signed [DW-1:0]   in_data;
   logic                   clr;
   logic                   smp_we;
   logic [AW-1:0]          smp_waddr;
   logic [DW-1:0]          smp_wdata;
   logic [AW-1:0]          smp_raddr;
   logic [AW-1:0]          coef_addr;
   logic [1:0]             alu_op_code;
   logic signed [ACCW-1:0] alu_result;
   logic signed [ACCW-1:0] alu_prev_acc;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [ACCW-1:0] out_data;
   logic                   busy;

   modport master (
      input  in_valid, in_data, clr, alu_result, out_ready,
      output in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_addr,
             alu_op_code, alu_prev_acc, out_valid, out_data, busy
   );

   modport slave (
      output in_valid, in_data, clr, alu_result, out_ready,
      input  in_ready, smp_we, smp_waddr, smp_wdata, smp_raddr, coef_addr,
             alu_op_code, alu_prev_acc, out_valid, out_data, busy
   );
endinterface
`default_nettype wire

// File: rtl/fir_mac_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_mac_ctrl                                                             |
// | Sequencer for a single-MAC FIR: delay-line RAM, coefficient ROM, ALU.    |
// | Optional macro FIR_SAT_EN: shift/saturate the result to DW bits.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_mac_ctrl #(
   parameter int NTAPS = 64,
   parameter int DW    = 16,
   parameter int ACCW  = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   fir_mac_if.master bus
);
   localparam int            AW       = $clog2(NTAPS);
   localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);
   localparam logic [1:0]    OP_RST   = 2'b00;
   localparam logic [1:0]    OP_MUL   = 2'b01;
   localparam logic [1:0]    OP_MAC   = 2'b10;

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [AW-1:0]          cnt_q, cnt_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          newest_q, newest_d;
   logic [AW-1:0]          k_q, k_d;
   logic signed [ACCW-1:0] out_data_q, out_data_d;
   logic signed [ACCW-1:0] result_fmt;

   logic                   in_ready_c;
   logic                   smp_we_c;
   logic [AW-1:0]          smp_waddr_c;
   logic [DW-1:0]          smp_wdata_c;
   logic [AW-1:0]          smp_raddr_c;
   logic [AW-1:0]          coef_addr_c;
   logic [1:0]             alu_op_c;

`ifdef FIR_SAT_EN
   localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
   logic signed [ACCW-1:0] shifted;

   always_comb begin
      shifted = $signed(bus.alu_result) >>> (DW - 1);
      if (shifted > SAT_MAX) begin
         result_fmt = SAT_MAX;
      end else if (shifted < SAT_MIN) begin
         result_fmt = SAT_MIN;
      end else begin
         result_fmt = shifted;
      end
   end
`else
   assign result_fmt = bus.alu_result;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_INIT;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         newest_q   <= '0;
         k_q        <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         newest_q   <= newest_d;
         k_q        <= k_d;
         out_data_q <= out_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_ptr_d    = wr_ptr_q;
      newest_d    = newest_q;
      k_d         = k_q;
      out_data_d  = out_data_q;
      in_ready_c  = 1'b0;
      smp_we_c    = 1'b0;
      smp_waddr_c = '0;
      smp_wdata_c = '0;
      smp_raddr_c = '0;
      coef_addr_c = '0;
      alu_op_c    = OP_RST;

      case (state_q)
         S_INIT: begin
            smp_we_c    = 1'b1;
            smp_waddr_c = cnt_q;
            if (cnt_q == LAST_IDX) begin
               cnt_d    = '0;
               wr_ptr_d = '0;
               state_d  = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            in_ready_c = !bus.clr;
            if (bus.clr) begin
               cnt_d   = '0;
               state_d = S_INIT;
            end else if (bus.in_valid) begin
               smp_we_c    = 1'b1;
               smp_waddr_c = wr_ptr_q;
               smp_wdata_c = bus.in_data;
               newest_d    = wr_ptr_q;
               wr_ptr_d    = wr_ptr_q + 1'b1;
               k_d         = '0;
               state_d     = S_MAC;
            end
         end
         S_MAC: begin
            // Newest sample pairs with h[0]; AW-bit subtraction wraps the delay line.
            coef_addr_c = k_q;
            smp_raddr_c = newest_q - k_q;
            alu_op_c    = (k_q == '0) ? OP_MUL : OP_MAC;
            if (k_q == LAST_IDX) begin
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DRAIN: begin
            out_data_d = result_fmt;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // Every output is held at zero while reset is asserted.
   assign bus.in_ready     = rst_n & in_ready_c;
   assign bus.smp_we       = rst_n & smp_we_c;
   assign bus.smp_waddr    = rst_n ? smp_waddr_c : '0;
   assign bus.smp_wdata    = rst_n ? smp_wdata_c : '0;
   assign bus.smp_raddr    = rst_n ? smp_raddr_c : '0;
   assign bus.coef_addr    = rst_n ? coef_addr_c : '0;
   assign bus.alu_op_code  = rst_n ? alu_op_c : OP_RST;
   assign bus.alu_prev_acc = rst_n ? bus.alu_result : '0;
   assign bus.out_valid    = rst_n & (state_q == S_OUT);
   assign bus.out_data     = rst_n ? out_data_q : '0;
   assign bus.busy         = rst_n & (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_fir_mac_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_mac_ctrl                                                          |
// | Self-checking bench: RAM/ROM/ALU models, convolution scoreboard.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fir_mac_ctrl;
   localparam int NTAPS = 64;
   localparam int DW    = 16;
   localparam int ACCW  = 32;
   localparam int AW    = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fir_mac_if #(.NTAPS(NTAPS), .DW(DW), .ACCW(ACCW)) bus ();

   fir_mac_ctrl #(.NTAPS(NTAPS), .DW(DW), .ACCW(ACCW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int tb_wr    = 0;

   // Memory and ALU models
   logic signed [DW-1:0]   smp_ram  [NTAPS];
   logic signed [DW-1:0]   coef_rom [NTAPS];
   logic signed [DW-1:0]   alu_d, alu_c;
   logic signed [ACCW-1:0] alu_prod;

   assign alu_d    = smp_ram[bus.smp_raddr];
   assign alu_c    = coef_rom[bus.coef_addr];
   assign alu_prod = alu_d * alu_c;

   always_ff @(posedge clk) begin
      if (bus.smp_we) smp_ram[bus.smp_waddr] <= bus.smp_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.alu_result <= '0;
      end else begin
         case (bus.alu_op_code)
            2'b01:   bus.alu_result <= alu_prod;
            2'b10:   bus.alu_result <= bus.alu_prev_acc + alu_prod;
            default: bus.alu_result <= '0;
         endcase
      end
   end

   // Reference convolution model
   int hist [NTAPS];
   logic signed [ACCW-1:0] exp_q [$];

   typedef struct {
      logic signed [DW-1:0] din;
      longint               raw;
   } vec_t;
   vec_t vtab [NTAPS + 2];

   function automatic void hist_clear();
      for (int i = 0; i < NTAPS; i++) hist[i] = 0;
   endfunction

   function automatic void hist_push(input int x);
      for (int i = NTAPS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = x;
   endfunction

   function automatic longint ref_raw();
      longint acc = 0;
      for (int k = 0; k < NTAPS; k++) acc += longint'(hist[k]) * longint'(coef_rom[k]);
      return acc;
   endfunction

   function automatic logic signed [ACCW-1:0] fmt(input longint raw);
      logic signed [ACCW-1:0] r;
      r = ACCW'(raw);
`ifdef FIR_SAT_EN
      begin
         longint s;
         s = longint'(r) >>> (DW - 1);
         if (s > longint'(32767)) s = 32767;
         if (s < longint'(-32768)) s = -32768;
         r = ACCW'(s);
      end
`endif
      return r;
   endfunction

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic wait_in_ready(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout actual=in_ready_low required=in_ready_high", name);
      end
   endtask

   // Drive one sample, push its expected result, wait for out_valid.
   task automatic send(input logic signed [DW-1:0] x, input logic signed [ACCW-1:0] e, input bit deep);
      int lat = 0;
      int newest;
      bit seen = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      wait_in_ready("send");
      newest = tb_wr;
      tb_wr  = (tb_wr + 1) % NTAPS;
      exp_q.push_back(e);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
         if (deep && lat == 0) chk("mac_op_first", bus.alu_op_code, 2'b01);
         if (deep && lat == 5) begin
            chk("mac_op_acc", bus.alu_op_code, 2'b10);
            chk("coef_addr", bus.coef_addr, 5);
            chk("smp_raddr", bus.smp_raddr, (newest - 5 + NTAPS) % NTAPS);
            chk("prev_acc", bus.alu_prev_acc, bus.alu_result);
            chk("mac_ready_busy_we", {bus.in_ready, bus.busy, bus.smp_we}, 3'b010);
         end
         @(posedge clk);
         lat++;
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL out_valid_timeout actual=none required=out_valid");
         if (exp_q.size() > 0) void'(exp_q.pop_back());
      end else if (deep) begin
         chk("latency", lat, NTAPS + 1);
      end
   endtask

   task automatic do_clr();
      @(posedge clk); #1;
      bus.clr      = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'sd123;
      @(negedge clk);
      chk("clr_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      bus.clr      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      @(negedge clk);
      chk("clr_to_init", {bus.busy, bus.smp_we, bus.smp_waddr, bus.smp_wdata}, {1'b1, 1'b1, 6'd0, 16'd0});
      hist_clear();
      tb_wr = 0;
      wait_in_ready("clr");
   endtask

   // Scoreboard pop on every output handshake
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output actual=%0d required=none", bus.out_data);
         end else begin
            chk("out_data", bus.out_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic signed [ACCW-1:0] held;
      int nv;

      for (int i = 0; i < NTAPS + 2; i++) begin
         vtab[i].din = (i == 0) ? 16'sd1 : 16'sd0;
         vtab[i].raw = (i < NTAPS) ? longint'(i + 1) : 64'sd0;
      end

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.clr       = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < NTAPS; k++) coef_rom[k] = DW'(k + 1);
      hist_clear();

      // Reset state and INIT sweep
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {bus.smp_we, bus.in_ready, bus.out_valid, bus.busy, bus.alu_op_code}, 6'd0);
      chk("rst_addr", {bus.smp_waddr, bus.smp_raddr, bus.coef_addr, bus.smp_wdata}, 34'd0);
      chk("rst_out_data", bus.out_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < NTAPS; i++) begin
         @(negedge clk);
         chk("init_write", {bus.smp_we, bus.smp_waddr, bus.smp_wdata, bus.busy, bus.in_ready},
             {1'b1, AW'(i), 16'd0, 1'b1, 1'b0});
      end
      @(negedge clk);
      chk("idle_ready_busy", {bus.in_ready, bus.busy}, 2'b10);

      // Impulse response from the vector table, h[k] = k+1
      for (int i = 0; i < NTAPS + 2; i++) begin
         hist_push(vtab[i].din);
         send(vtab[i].din, fmt(vtab[i].raw), i == 0);
      end

      // clr with in_valid, then steady 1000 through the pointer wrap
      do_clr();
      for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'sd1;
      for (int i = 0; i < 130; i++) begin
         hist_push(1000);
         send(16'sd1000, fmt(ref_raw()), i == 100);
      end

      // Backpressure on the result port
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      hist_push(777);
      send(16'sd777, fmt(ref_raw()), 1'b0);
      held = bus.out_data;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.in_data  = 16'sd999;
         @(negedge clk);
         chk("bp_valid", bus.out_valid, 1'b1);
         chk("bp_data", bus.out_data, held);
         chk("bp_no_accept", {bus.in_ready, bus.smp_we}, 2'b00);
      end
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_release", bus.out_valid, 1'b0);

      // Large input, h = 1024
      do_clr();
      for (int k = 0; k < NTAPS; k++) coef_rom[k] = 16'sd1024;
      for (int i = 0; i < NTAPS + 1; i++) begin
         hist_push(32767);
         send(16'sd32767, fmt(ref_raw()), 1'b0);
      end

      // Reset in the middle of MAC at k = 30
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'sd555;
      wait_in_ready("rst_mac");
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("mac_k30", bus.coef_addr, 30);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mac_ctrl", {bus.smp_we, bus.busy, bus.in_ready, bus.out_valid, bus.alu_op_code}, 6'd0);
      chk("rst_mac_addr", {bus.smp_raddr, bus.coef_addr}, 12'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      hist_clear();
      tb_wr = 0;
      @(negedge clk);
      chk("rst_reinit", {bus.smp_we, bus.smp_waddr, bus.busy}, {1'b1, 6'd0, 1'b1});
      chk("rst_out_data_cleared", bus.out_data, 0);
      wait_in_ready("after_rst");
      nv = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (bus.out_valid) nv++;
      end
      chk("no_out_after_rst", nv, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fir_mac_ctrl.md
FIR_MAC_CTRL -- requirements
Module: fir_mac_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 64, tap count; power of two; address width AW = log2(NTAPS).
REQ-002 SHALL have parameter DW, default 16, sample width.
REQ-003 SHALL have parameter ACCW, default 32, ALU accumulator width.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports:
- in_valid  in  1  input sample valid
- in_ready  out  1  sample accepted when in_valid and in_ready are both high at a rising edge
- in_data  in  DW  signed sample
- clr  in  1  request zeroing of the delay line
- smp_we  out  1  sample RAM write enable
- smp_waddr  out  AW  sample RAM write address
- smp_wdata  out  DW  sample RAM write data
- smp_raddr  out  AW  sample RAM read address (asynchronous-read RAM; read data feeds ALU data)
- coef_addr  out  AW  coefficient ROM address (asynchronous read; read data feeds ALU coeff)
- alu_op_code  out  2  ALU operation: 00 reset, 01 multiply, 10 multiply-accumulate
- alu_result  in  ACCW  signed ALU result, registered, 1-cycle latency
- alu_prev_acc  out  ACCW  equals alu_result combinationally
- out_valid  out  1  filter output valid
- out_ready  in  1  output consumed
- out_data  out  ACCW  signed filter output
- busy  out  1  high in every state except IDLE

Function
REQ-006 SHALL implement the states INIT, IDLE, MAC, DRAIN, OUT.
REQ-007 INIT SHALL drive smp_we=1, smp_wdata=0, smp_waddr=cnt, for cnt = 0..NTAPS-1, one address per cycle, and SHALL then go to IDLE with wr_ptr=0.
REQ-008 IDLE SHALL drive in_ready = !clr.
- clr high goes to INIT; clr wins over a simultaneous in_valid.
- An accepted sample drives smp_we=1, smp_waddr=wr_ptr, smp_wdata=in_data; newest<=wr_ptr; wr_ptr<=wr_ptr+1 mod NTAPS; tap counter k<=0; next state MAC.
REQ-009 MAC SHALL drive, for k = 0..NTAPS-1 (one tap per cycle):
- coef_addr=k
- smp_raddr=(newest-k) mod NTAPS
- alu_op_code=01 when k=0, 10 otherwise
After k=NTAPS-1 the next state SHALL be DRAIN.
REQ-010 DRAIN SHALL drive alu_op_code=00, latch the filter result from alu_result into out_data, and go to OUT.
REQ-011 OUT SHALL hold out_valid=1 and keep out_data stable until out_ready=1 at a rising edge, then go to IDLE.
REQ-012 Latency SHALL be exactly NTAPS+1 rising edges from the accept edge to the first cycle with out_valid=1 (65 for NTAPS=64).
REQ-013 Outside MAC, alu_op_code SHALL be 00; outside INIT and the accept cycle, smp_we SHALL be 0.
REQ-014 in_ready SHALL be 0 in every state except IDLE.
REQ-015 clr SHALL be ignored outside IDLE.
REQ-016 wr_ptr and smp_raddr SHALL wrap modulo NTAPS with no discontinuity.

Reset
REQ-017 rst_n low SHALL immediately force state INIT with cnt=0, wr_ptr=0, newest=0, k=0, out_data=0.
REQ-018 While rst_n is low, all outputs SHALL be 0; INIT writes begin on the first edge after deassertion.
REQ-019 Reset during MAC or OUT SHALL discard the in-flight result; no out_valid pulse SHALL follow.

Configuration
REQ-020 With FIR_SAT_EN defined, out_data SHALL be the latched result arithmetically shifted right by DW-1, saturated to [-2^(DW-1), 2^(DW-1)-1], and sign-extended to ACCW.
REQ-021 Without FIR_SAT_EN, out_data SHALL be the raw ACCW-bit result, wrapping on overflow.

Verification
REQ-022 Release reset: smp_waddr steps 0..63 with smp_wdata=0; in_ready rises in the cycle after the last INIT write; busy=1 throughout INIT.
REQ-023 Impulse, ROM h[k]=k+1, bench ALU model: input 1 then zeros gives outputs 1,2,...,64, then 0 from the 65th sample on.
REQ-024 Steady input 1000, h[k]=1, no macro: the 64th output and all later outputs equal 64000; 130 samples exercise the wr_ptr 63->0 wrap.
REQ-025 out_ready held low for 10 cycles: out_valid and out_data stay stable, in_ready=0, and in_valid is not accepted.
REQ-026 Steady input 32767, h=1024: the 64th output is 2147418112 without the macro; with FIR_SAT_EN it is 32767.
REQ-027 Reset asserted at k=30, and clr together with in_valid in IDLE: both return the block to INIT, no output is produced, and no sample is accepted.
